// File: rtl/b_risc_pkg.sv
// rtl/b_risc_pkg.sv - shared register-file defaults and index helpers
package b_risc_pkg;

  localparam int REG_W_DEFAULT     = 32;
  localparam int REG_COUNT_DEFAULT = 32;

  function automatic int reg_idx_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  // Register 0 and indices past the end of a non-power-of-two file are inert.
  function automatic logic idx_ok(input int idx, input int count);
    return (idx > 0) && (idx < count);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy bits: reserve, write-clear, flush, read lookup
module reg_scoreboard
  import b_risc_pkg::*;
#(
  parameter int REG_COUNT = REG_COUNT_DEFAULT,
  parameter int RD_PORTS  = 2,
  parameter int WR_PORTS  = 2,
  parameter int REG_IDX_W = reg_idx_w(REG_COUNT)
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic                          rsv_en,
  input  logic [REG_IDX_W-1:0]          rsv_reg,
  input  logic                          flush,
  input  logic [WR_PORTS-1:0]           wr_valid,
  input  logic [WR_PORTS*REG_IDX_W-1:0] wr_reg,
  input  logic [RD_PORTS*REG_IDX_W-1:0] rd_reg,
  input  logic [RD_PORTS-1:0]           rd_fwd,
  output logic [RD_PORTS-1:0]           rd_busy
);

  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_nxt;

  // Priority low to high: write clears, reserve sets, flush clears everything.
  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < WR_PORTS; w++) begin
      if (wr_valid[w]) busy_nxt[wr_reg[w*REG_IDX_W +: REG_IDX_W]] = 1'b0;
    end
    if (rsv_en && idx_ok(int'(rsv_reg), REG_COUNT)) busy_nxt[rsv_reg] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) busy <= '0;
    else          busy <= busy_nxt;
  end

  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (aresetn && idx_ok(int'(rd_reg[p*REG_IDX_W +: REG_IDX_W]), REG_COUNT) && !rd_fwd[p])
        rd_busy[p] = busy[rd_reg[p*REG_IDX_W +: REG_IDX_W]];
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with write bypass and busy scoreboard
module register_file_mp
  import b_risc_pkg::*;
#(
  parameter int REG_W     = REG_W_DEFAULT,
  parameter int REG_COUNT = REG_COUNT_DEFAULT,
  parameter int RD_PORTS  = 2,
  parameter int WR_PORTS  = 2,
  parameter int BYPASS    = 1,
  parameter int REG_IDX_W = reg_idx_w(REG_COUNT)
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [RD_PORTS*REG_IDX_W-1:0] rd_reg,
  output logic [RD_PORTS*REG_W-1:0]     rd_data,
  output logic [RD_PORTS-1:0]           rd_busy,
  input  logic [WR_PORTS-1:0]           wr_en,
  input  logic [WR_PORTS*REG_IDX_W-1:0] wr_reg,
  input  logic [WR_PORTS*REG_W-1:0]     wr_data,
  input  logic                          rsv_en,
  input  logic [REG_IDX_W-1:0]          rsv_reg,
  input  logic                          flush
);

  logic [REG_W-1:0]    regs [REG_COUNT];
  logic [WR_PORTS-1:0] wr_valid;
  logic [RD_PORTS-1:0] rd_fwd;
  logic [REG_W-1:0]    fwd_data [RD_PORTS];

  always_comb begin
    wr_valid = '0;
    for (int w = 0; w < WR_PORTS; w++)
      wr_valid[w] = wr_en[w] && idx_ok(int'(wr_reg[w*REG_IDX_W +: REG_IDX_W]), REG_COUNT);
  end

  // Later ports overwrite earlier ones, so the highest-numbered port wins.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      for (int w = 0; w < WR_PORTS; w++) begin
        if (wr_valid[w]) regs[wr_reg[w*REG_IDX_W +: REG_IDX_W]] <= wr_data[w*REG_W +: REG_W];
      end
    end
  end

  always_comb begin
    rd_fwd  = '0;
    rd_data = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      fwd_data[p] = '0;
      for (int w = 0; w < WR_PORTS; w++) begin
        if (BYPASS != 0 && wr_valid[w] &&
            wr_reg[w*REG_IDX_W +: REG_IDX_W] == rd_reg[p*REG_IDX_W +: REG_IDX_W]) begin
          rd_fwd[p]   = 1'b1;
          fwd_data[p] = wr_data[w*REG_W +: REG_W];
        end
      end
      if (aresetn && idx_ok(int'(rd_reg[p*REG_IDX_W +: REG_IDX_W]), REG_COUNT))
        rd_data[p*REG_W +: REG_W] = rd_fwd[p] ? fwd_data[p] : regs[rd_reg[p*REG_IDX_W +: REG_IDX_W]];
    end
  end

  reg_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .RD_PORTS  (RD_PORTS),
    .WR_PORTS  (WR_PORTS),
    .REG_IDX_W (REG_IDX_W)
  ) u_scoreboard (
    .clk      (clk),
    .aresetn  (aresetn),
    .rsv_en   (rsv_en),
    .rsv_reg  (rsv_reg),
    .flush    (flush),
    .wr_valid (wr_valid),
    .wr_reg   (wr_reg),
    .rd_reg   (rd_reg),
    .rd_fwd   (rd_fwd),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - self-checking bench for register_file_mp
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [9:0]  rd_reg;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_reg;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_reg;
  logic        flush;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got, e;
  logic [31:0] mdl [32];

  always #5 clk = ~clk;

  register_file_mp dut (
    .clk(clk), .aresetn(aresetn), .rd_reg(rd_reg), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .flush(flush)
  );

  task automatic idle();
    wr_en = '0; wr_reg = '0; wr_data = '0; rsv_en = 1'b0; rsv_reg = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_rd(input int p, input logic [4:0] idx);
    rd_reg[p*5 +: 5] = idx;
  endtask

  task automatic set_wr(input int w, input logic [4:0] idx, input logic [31:0] d);
    wr_en[w] = 1'b1; wr_reg[w*5 +: 5] = idx; wr_data[w*32 +: 32] = d;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; idle(); rd_reg = '0;
    set_wr(0, 5'd1, 32'hFFFF_FFFF); rsv_en = 1'b1; rsv_reg = 5'd1; flush = 1'b1;
    set_rd(0, 5'd1); set_rd(1, 5'd1);
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #2;
    got = rd_data[31:0]; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL reset_data got=%h exp=%h", got, e); end
    got = {30'b0, rd_busy}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL reset_busy got=%h exp=%h", got, e); end
    idle(); aresetn = 1'b1;
    step();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #2;
    got = rd_data[63:32]; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL post_reset_r1 got=%h exp=%h", got, e); end
    got = {30'b0, rd_busy}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL post_reset_busy got=%h exp=%h", got, e); end
  endtask

  task automatic test_r0();
    idle(); set_wr(0, 5'd0, 32'h1); rsv_en = 1'b1; rsv_reg = 5'd0; set_rd(0, 5'd0);
    exp_q.push_back(32'h0);
    #2;
    got = rd_data[31:0]; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL r0_same_cycle got=%h exp=%h", got, e); end
    step(); idle();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #2;
    got = rd_data[31:0]; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL r0_data got=%h exp=%h", got, e); end
    got = {31'b0, rd_busy[0]}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL r0_busy got=%h exp=%h", got, e); end
  endtask

  task automatic test_fill();
    for (int i = 1; i < 32; i++) begin
      idle(); mdl[i] = $urandom; set_wr(0, 5'(i), mdl[i]); set_rd(1, 5'd0);
      step(); idle(); set_rd(1, 5'(i));
      exp_q.push_back(mdl[i]);
      #2;
      got = rd_data[63:32]; e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL fill_r%0d got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_collision();
    idle(); set_wr(0, 5'd5, 32'hAAAA_AAAA); set_wr(1, 5'd5, 32'h5555_5555); set_rd(0, 5'd5);
    exp_q.push_back(32'h5555_5555);
    #2;
    got = rd_data[31:0]; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL collision_bypass got=%h exp=%h", got, e); end
    step(); idle();
    exp_q.push_back(32'h5555_5555);
    #2;
    got = rd_data[31:0]; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL collision_commit got=%h exp=%h", got, e); end
  endtask

  task automatic test_reserve();
    idle(); rsv_en = 1'b1; rsv_reg = 5'd7; set_rd(0, 5'd7);
    step(); idle();
    exp_q.push_back(32'h1);
    #2;
    got = {31'b0, rd_busy[0]}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL rsv_busy got=%h exp=%h", got, e); end
    set_wr(1, 5'd7, 32'h1234);
    exp_q.push_back(32'h0); exp_q.push_back(32'h1234);
    #1;
    got = {31'b0, rd_busy[0]}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL rsv_write_busy got=%h exp=%h", got, e); end
    got = rd_data[31:0]; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL rsv_write_data got=%h exp=%h", got, e); end
    step(); idle();
    exp_q.push_back(32'h0); exp_q.push_back(32'h1234);
    #2;
    got = {31'b0, rd_busy[0]}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL rsv_cleared got=%h exp=%h", got, e); end
    got = rd_data[31:0]; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL rsv_data got=%h exp=%h", got, e); end
  endtask

  task automatic test_flush();
    idle(); rsv_en = 1'b1; rsv_reg = 5'd3; set_wr(0, 5'd3, 32'h10); set_rd(0, 5'd3); set_rd(1, 5'd4);
    step(); idle();
    exp_q.push_back(32'h10); exp_q.push_back(32'h1);
    #2;
    got = rd_data[31:0]; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL rsv_wr_data got=%h exp=%h", got, e); end
    got = {31'b0, rd_busy[0]}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL rsv_wr_busy got=%h exp=%h", got, e); end
    flush = 1'b1; rsv_en = 1'b1; rsv_reg = 5'd4;
    step(); idle();
    exp_q.push_back(32'h0);
    #2;
    got = {30'b0, rd_busy}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL flush_busy got=%h exp=%h", got, e); end
  endtask

  task automatic test_async_reset();
    idle(); set_wr(0, 5'd9, 32'hDEAD); rsv_en = 1'b1; rsv_reg = 5'd10; set_rd(0, 5'd9); set_rd(1, 5'd10);
    step(); idle();
    exp_q.push_back(32'hDEAD); exp_q.push_back(32'h2);
    #1;
    got = rd_data[31:0]; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL pre_rst_data got=%h exp=%h", got, e); end
    got = {30'b0, rd_busy}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL pre_rst_busy got=%h exp=%h", got, e); end
    aresetn = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    got = rd_data[31:0]; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL async_rst_data got=%h exp=%h", got, e); end
    got = {30'b0, rd_busy}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL async_rst_busy got=%h exp=%h", got, e); end
    step(); aresetn = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #2;
    got = rd_data[31:0]; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL after_rst_r9 got=%h exp=%h", got, e); end
    got = {30'b0, rd_busy}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL after_rst_busy got=%h exp=%h", got, e); end
  endtask

  initial begin
    test_reset();
    test_r0();
    test_fill();
    test_collision();
    test_reserve();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter REG_W, default 32, data width of each register.
REQ-002 SHALL have parameter REG_COUNT, default 32, number of architectural registers; REG_IDX_W = $clog2(REG_COUNT).
REQ-003 SHALL have parameter RD_PORTS, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter WR_PORTS, default 2, number of write ports (1..2).
REQ-005 SHALL have parameter BYPASS, default 1, same-cycle write-to-read forwarding enable.
REQ-006 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-007 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port rd_reg  input  RD_PORTS*REG_IDX_W  packed read indices, port p at bits [p*REG_IDX_W +: REG_IDX_W].
REQ-009 SHALL have port rd_data  output  RD_PORTS*REG_W  packed read data, same packing.
REQ-010 SHALL have port rd_busy  output  RD_PORTS  per-port scoreboard busy flag for the indexed register.
REQ-011 SHALL have port wr_en  input  WR_PORTS  per-port write enable.
REQ-012 SHALL have port wr_reg  input  WR_PORTS*REG_IDX_W  packed write indices.
REQ-013 SHALL have port wr_data  input  WR_PORTS*REG_W  packed write data.
REQ-014 SHALL have port rsv_en  input  1  reserve request: mark rsv_reg busy (pending producer issued).
REQ-015 SHALL have port rsv_reg  input  REG_IDX_W  register to reserve.
REQ-016 SHALL have port flush  input  1  synchronous clear of all busy bits (pipeline flush).

Function
REQ-017 Register 0 SHALL always read 0, ignore writes, never be busy, ignore reservations.
REQ-018 Reads SHALL be combinational: rd_data reflects array contents in the same cycle as rd_reg.
REQ-019 Writes SHALL commit on rising clk when wr_en[w]=1; visible in array from next cycle.
REQ-020 Two write ports to same nonzero register same cycle: highest-numbered port SHALL win; the other is discarded.
REQ-021 BYPASS=1: read of a register being written this cycle SHALL return the winning wr_data combinationally and rd_busy=0 for that port.
REQ-022 BYPASS=0: same-cycle read SHALL return old contents and registered busy bit.
REQ-023 Each register SHALL have a busy bit; rsv_en=1 sets busy[rsv_reg] at next edge.
REQ-024 A write to register r SHALL clear busy[r] at next edge.
REQ-025 Reserve and write to the same r in one cycle: reserve SHALL win (busy stays/becomes 1), data still committed.
REQ-026 flush=1 SHALL clear all busy bits at next edge, overriding same-cycle rsv_en; writes that cycle still commit.
REQ-027 rd_busy[p] SHALL be 0 when rd_reg[p]=0 regardless of other inputs.
REQ-028 Out-of-range indices (>= REG_COUNT when not a power of two) SHALL read 0, busy 0, and be ignored for write/reserve.

Reset
REQ-029 aresetn=0 SHALL asynchronously clear all registers to 0 and all busy bits to 0.
REQ-030 Writes, reservations and flush during reset SHALL be ignored; first update occurs on first rising edge after deassertion.
REQ-031 rd_data SHALL read 0 on every port and rd_busy 0 while in reset, BYPASS notwithstanding.

Structure
REQ-032 Default REG_W, REG_COUNT and the index width function SHALL live in the shared b_risc package; port/bypass parameters stay local.
REQ-033 Busy-bit logic SHALL be a sub-module reg_scoreboard (rsv/write-clear/flush/read lookup); data array and bypass muxing stay in register_file_mp.

Verification
REQ-034 After reset, write 1 to r0 via port 0 -> next cycle rd_data port 0 for r0 = 0, rd_busy = 0.
REQ-035 Write $urandom to r1..r31 via port 0, read back via port 1 next cycle -> every read matches written value.
REQ-036 Same cycle port0 writes r5=0xAAAA_AAAA, port1 writes r5=0x5555_5555 -> r5 = 0x5555_5555; with BYPASS=1 same-cycle read of r5 = 0x5555_5555.
REQ-037 Reserve r7; next cycle rd_busy=1 for r7; write r7=0x1234 -> same cycle (BYPASS=1) rd_busy=0, data 0x1234; next cycle busy=0.
REQ-038 Reserve r3 and write r3=0x10 same cycle -> r3=0x10, busy=1; then flush with rsv r4 -> all busy=0.
REQ-039 Assert aresetn=0 mid-run with r9=0xDEAD and busy set -> immediately r9 reads 0 and all rd_busy=0.
